// File: rtl/u_rv_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate format selector and
// the default fetch squash depth.
package u_rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam int SQ_N_DEF = 2;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_t;

  // Unknown opcodes fall into IMM_NONE, which also yields a zero immediate.
  function automatic imm_t imm_sel(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_sel = IMM_I;
      OPC_STORE:                                  imm_sel = IMM_S;
      OPC_BRANCH:                                 imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:                         imm_sel = IMM_U;
      OPC_JAL:                                    imm_sel = IMM_J;
      default:                                    imm_sel = IMM_NONE;
    endcase
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: opc_legal = 1'b1;
      default:                                            opc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/u_regfile.sv
// 32x32 register file, two combinational read ports, one synchronous write port,
// x0 hardwired to zero. IDU_RF_BYPASS_EN forwards a same-cycle write to the reads.
module u_regfile
  import u_rv_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_mem [31:1];
  logic        w_wr;

  assign w_wr = i_we && (i_wa != 5'd0);

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[i_wa] <= i_wd;
  end

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != 5'd0) o_rd1 = r_mem[i_ra1];
    if (i_ra2 != 5'd0) o_rd2 = r_mem[i_ra2];
`ifdef IDU_RF_BYPASS_EN
    if (w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
    if (w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
`endif
  end

endmodule

// File: rtl/u_idu.sv
// RV32I decode stage: operand read, immediate generation, illegal check and
// wrong-path squash after reset/redirect. Optional macro: IDU_RF_BYPASS_EN.
module u_idu
  import u_rv_pkg::*;
#(
  parameter int SQ_N = SQ_N_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ifu_pc,
  input  logic [31:0] ifu_ins,
  input  logic        branch,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_dat,
  output logic        idu_vld,
  output logic [31:0] idu_pc,
  output logic [6:0]  idu_opc,
  output logic [2:0]  idu_f3,
  output logic [6:0]  idu_f7,
  output logic [4:0]  idu_rd,
  output logic [4:0]  idu_rs1,
  output logic [4:0]  idu_rs2,
  output logic [31:0] idu_rs1_dat,
  output logic [31:0] idu_rs2_dat,
  output logic [31:0] idu_imm,
  output logic        idu_ill
);

  localparam logic [1:0] SQ_LOAD = SQ_N[1:0];

  logic [1:0]  r_sq_cnt;
  logic [6:0]  w_opc;
  logic        w_acc;
  logic        w_ill;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_dat;
  logic [31:0] w_rs2_dat;
  imm_t        w_sel;

  assign w_opc = ifu_ins[6:0];
  assign w_acc = !branch && (r_sq_cnt == 2'd0);
  assign w_sel = imm_sel(w_opc);
  assign w_ill = (ifu_ins[1:0] != 2'b11) || !opc_legal(w_opc);

  u_regfile u_rf (
    .clk   (clk),
    .i_we  (wb_we),
    .i_wa  (wb_rd),
    .i_wd  (wb_dat),
    .i_ra1 (ifu_ins[19:15]),
    .i_ra2 (ifu_ins[24:20]),
    .o_rd1 (w_rs1_dat),
    .o_rd2 (w_rs2_dat)
  );

  always_comb begin
    w_imm = '0;
    case (w_sel)
      IMM_I:   w_imm = {{20{ifu_ins[31]}}, ifu_ins[31:20]};
      IMM_S:   w_imm = {{20{ifu_ins[31]}}, ifu_ins[31:25], ifu_ins[11:7]};
      IMM_B:   w_imm = {{19{ifu_ins[31]}}, ifu_ins[31], ifu_ins[7], ifu_ins[30:25],
                        ifu_ins[11:8], 1'b0};
      IMM_U:   w_imm = {ifu_ins[31:12], 12'b0};
      IMM_J:   w_imm = {{11{ifu_ins[31]}}, ifu_ins[31], ifu_ins[19:12], ifu_ins[20],
                        ifu_ins[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // rd=0 downstream means "no register write".
  always_comb begin
    w_rd = ifu_ins[11:7];
    if (w_ill || (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH)) w_rd = 5'd0;
  end

  // idu_vld qualifies the whole idu_* bundle for one cycle; there is no
  // backpressure, execute must consume every valid slot. Squashed slots clear
  // vld/rd/ill and leave the remaining fields holding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sq_cnt    <= SQ_LOAD;
      idu_vld     <= 1'b0;
      idu_pc      <= '0;
      idu_opc     <= '0;
      idu_f3      <= '0;
      idu_f7      <= '0;
      idu_rd      <= '0;
      idu_rs1     <= '0;
      idu_rs2     <= '0;
      idu_rs1_dat <= '0;
      idu_rs2_dat <= '0;
      idu_imm     <= '0;
      idu_ill     <= 1'b0;
    end else begin
      if (branch)                 r_sq_cnt <= SQ_LOAD;
      else if (r_sq_cnt != 2'd0)  r_sq_cnt <= r_sq_cnt - 2'd1;
      if (w_acc) begin
        idu_vld     <= 1'b1;
        idu_pc      <= ifu_pc;
        idu_opc     <= w_opc;
        idu_f3      <= ifu_ins[14:12];
        idu_f7      <= ifu_ins[31:25];
        idu_rd      <= w_rd;
        idu_rs1     <= ifu_ins[19:15];
        idu_rs2     <= ifu_ins[24:20];
        idu_rs1_dat <= w_rs1_dat;
        idu_rs2_dat <= w_rs2_dat;
        idu_imm     <= w_imm;
        idu_ill     <= w_ill;
      end else begin
        idu_vld <= 1'b0;
        idu_rd  <= 5'd0;
        idu_ill <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_u_idu.sv
// Bench for u_idu: reference decode/regfile/squash model feeding an expected queue.
module tb_u_idu;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] ifu_pc, ifu_ins, wb_dat;
  logic        branch, wb_we;
  logic [4:0]  wb_rd;
  logic        idu_vld, idu_ill;
  logic [31:0] idu_pc, idu_rs1_dat, idu_rs2_dat, idu_imm;
  logic [6:0]  idu_opc, idu_f7;
  logic [2:0]  idu_f3;
  logic [4:0]  idu_rd, idu_rs1, idu_rs2;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          sq;
  exp_t        last;
  exp_t        exp_q[$];
  logic [31:0] rf [32];
  logic [31:0] pc;
  logic [6:0]  ops [11];

  u_idu dut (
    .clk(clk), .rstn(rstn), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins), .branch(branch),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_dat(wb_dat), .idu_vld(idu_vld),
    .idu_pc(idu_pc), .idu_opc(idu_opc), .idu_f3(idu_f3), .idu_f7(idu_f7),
    .idu_rd(idu_rd), .idu_rs1(idu_rs1), .idu_rs2(idu_rs2),
    .idu_rs1_dat(idu_rs1_dat), .idu_rs2_dat(idu_rs2_dat), .idu_imm(idu_imm),
    .idu_ill(idu_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".vld"}, 32'(idu_vld), 32'(e.vld));
    chk({tag, ".pc"},  idu_pc, e.pc);
    chk({tag, ".opc"}, 32'(idu_opc), 32'(e.opc));
    chk({tag, ".f3"},  32'(idu_f3), 32'(e.f3));
    chk({tag, ".f7"},  32'(idu_f7), 32'(e.f7));
    chk({tag, ".rd"},  32'(idu_rd), 32'(e.rd));
    chk({tag, ".rs1"}, 32'(idu_rs1), 32'(e.rs1));
    chk({tag, ".rs2"}, 32'(idu_rs2), 32'(e.rs2));
    chk({tag, ".d1"},  idu_rs1_dat, e.d1);
    chk({tag, ".d2"},  idu_rs2_dat, e.d2);
    chk({tag, ".imm"}, idu_imm, e.imm);
    chk({tag, ".ill"}, 32'(idu_ill), 32'(e.ill));
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef IDU_RF_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return rf[a];
  endfunction

  function automatic exp_t decode(input logic [31:0] p, input logic [31:0] ins, input logic we,
                                  input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [11:0] s12;
    logic        legal;
    e.vld = 1'b1;  e.pc = p;  e.opc = ins[6:0];  e.f3 = ins[14:12];  e.f7 = ins[31:25];
    e.rs1 = ins[19:15];  e.rs2 = ins[24:20];
    e.d1 = rf_read(ins[19:15], we, wa, wd);
    e.d2 = rf_read(ins[24:20], we, wa, wd);
    legal = ins[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                             7'h63, 7'h67, 7'h6F, 7'h73};
    e.ill = !legal;
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'($signed(ins) >>> 20);
      7'h23: e.imm = {{20{s12[11]}}, s12};
      7'h63: e.imm = {{19{b13[12]}}, b13};
      7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
      7'h6F: e.imm = {{11{j21[20]}}, j21};
      default: e.imm = 32'd0;
    endcase
    e.rd = (e.ill || ins[6:0] == 7'h23 || ins[6:0] == 7'h63) ? 5'd0 : ins[11:7];
    return e;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [31:0] p, input logic [31:0] ins, input logic br,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    ifu_pc = p;  ifu_ins = ins;  branch = br;  wb_we = we;  wb_rd = wa;  wb_dat = wd;
    if (!br && sq == 0) e = decode(p, ins, we, wa, wd);
    else begin
      e = last;  e.vld = 1'b0;  e.rd = 5'd0;  e.ill = 1'b0;
    end
    exp_q.push_back(e);
    last = e;
    if (br) sq = 2;
    else if (sq > 0) sq--;
    @(posedge clk);
    #1;
    if (we && wa != 5'd0) rf[wa] = wd;
    chk_all("slot", exp_q.pop_front());
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 4) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
    return ins;
  endfunction

  initial begin
    logic [31:0] old;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    rstn = 1'b0;  ifu_pc = '0;  ifu_ins = '0;  branch = 1'b0;
    wb_we = 1'b0;  wb_rd = '0;  wb_dat = '0;
    last = '0;  sq = 2;
    rf[0] = 32'd0;
    repeat (2) @(negedge clk);
    chk_all("reset", '0);
    rstn = 1'b1;

    // Two junk fetch slots, then PC 0 onward; fill x1..x31 with known values.
    pc = 32'd0;
    for (int k = 1; k < 32; k++) begin
      if (k <= 2) step(32'hBAD0_0000 + 32'(k), $urandom, 1'b0, 1'b1, 5'(k), $urandom);
      else begin
        step(pc, 32'h0000_0013, 1'b0, 1'b1, 5'(k), $urandom);
        if (k == 3) begin
          chk("first_vld", 32'(idu_vld), 32'd1);
          chk("first_pc", idu_pc, 32'd0);
        end
        pc += 4;
      end
    end

    step(pc, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("addi_rd", 32'(idu_rd), 32'd1);
    chk("addi_imm", idu_imm, 32'd5);
    chk("addi_d1", idu_rs1_dat, 32'd0);
    pc += 4;
    step(pc, 32'hFE00_0EE3, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq_imm", idu_imm, 32'hFFFF_FFFC);
    chk("beq_rd", 32'(idu_rd), 32'd0);
    pc += 4;

    old = rf[3];
    step(pc, 32'h0001_8233, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
`ifdef IDU_RF_BYPASS_EN
    chk("byp_d1", idu_rs1_dat, 32'hDEAD_BEEF);
`else
    chk("byp_d1", idu_rs1_dat, old);
`endif
    pc += 4;
    step(pc, 32'h0001_8233, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("wr_late_d1", idu_rs1_dat, 32'hDEAD_BEEF);
    pc += 4;
    step(pc, 32'h0000_0013, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    pc += 4;
    step(pc, 32'h0000_02B3, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0_d1", idu_rs1_dat, 32'd0);
    pc += 4;

    step(pc, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ill0_vld", 32'(idu_vld), 32'd1);
    chk("ill0_ill", 32'(idu_ill), 32'd1);
    pc += 4;
    step(pc, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ill1_ill", 32'(idu_ill), 32'd1);
    chk("ill1_rd", 32'(idu_rd), 32'd0);
    pc += 4;

    // Single redirect: slots T..T+2 squashed, T+3 carries the target.
    step(pc, rnd_ins(), 1'b1, 1'b0, 5'd0, 32'd0);
    step(pc + 4, rnd_ins(), 1'b0, 1'b0, 5'd0, 32'd0);
    step(pc + 8, rnd_ins(), 1'b0, 1'b0, 5'd0, 32'd0);
    chk("br_sq_vld", 32'(idu_vld), 32'd0);
    step(32'h100, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("br_tgt_vld", 32'(idu_vld), 32'd1);
    chk("br_tgt_pc", idu_pc, 32'h100);
    // Back-to-back redirect restarts the window.
    step(32'h104, rnd_ins(), 1'b1, 1'b0, 5'd0, 32'd0);
    step(32'h108, rnd_ins(), 1'b1, 1'b0, 5'd0, 32'd0);
    step(32'h10C, rnd_ins(), 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h110, rnd_ins(), 1'b0, 1'b0, 5'd0, 32'd0);
    chk("br2_sq_vld", 32'(idu_vld), 32'd0);
    step(32'h200, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("br2_tgt_pc", idu_pc, 32'h200);

    pc = 32'h204;
    for (int i = 0; i < 60; i++) begin
      step(pc, rnd_ins(), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom);
      pc += 4;
    end

    // Asynchronous reset mid-stream clears outputs before any clock edge.
    wb_we = 1'b0;
    step(pc, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    #2 rstn = 1'b0;
    #1 chk_all("midrst", '0);
    last = '0;  sq = 2;
    @(negedge clk);
    rstn = 1'b1;
    step(32'hBAD0_0001, $urandom, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'hBAD0_0002, $urandom, 1'b0, 1'b0, 5'd0, 32'd0);
    step(32'h0, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("rerst_pc", idu_pc, 32'd0);
    chk("rerst_vld", 32'(idu_vld), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u_idu.md
# u_idu

Instruction decode stage of the RV32I core, directly downstream of the fetch unit. Each cycle it takes the fetch unit's registered `ifu_pc`/`ifu_ins` pair and decodes the instruction. It reads two operands from an internal 32x32 register file and generates the sign-extended immediate, then registers everything toward execute with a valid bit. It also discards wrong-path instructions: the two that the fetch pipeline already holds when a branch redirect occurs, and the two that fetch produces before its first real instruction after reset.

## Interface
- `SQ_N`, default 2: fetch pipeline depth in slots squashed after a redirect or reset.
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `ifu_pc` input 32: PC of `ifu_ins`.
- `ifu_ins` input 32: fetched instruction, new every cycle, with no valid signal.
- `branch` input 1: redirect from execute; the same net drives the fetch unit.
- `wb_we` input 1: register file write enable.
- `wb_rd` input 5: write index.
- `wb_dat` input 32: write data.
- `idu_vld` output 1: decoded instruction valid.
- `idu_pc` output 32: PC.
- `idu_opc` output 7: `ins[6:0]`.
- `idu_f3` output 3: `ins[14:12]`.
- `idu_f7` output 7: `ins[31:25]`.
- `idu_rd` output 5: destination index.
- `idu_rs1` output 5: source 1 index.
- `idu_rs2` output 5: source 2 index.
- `idu_rs1_dat` output 32: source 1 operand.
- `idu_rs2_dat` output 32: source 2 operand.
- `idu_imm` output 32: sign-extended immediate.
- `idu_ill` output 1: illegal instruction flag, meaningful only when `idu_vld`=1.

## Operation
**Squash counter** `sq_cnt`:
- Width is 2 bits. It resets to `SQ_N`.
- A cycle with `branch`=1 loads `SQ_N`, even if `sq_cnt` is already nonzero.
- Otherwise, when `sq_cnt` is nonzero, it decrements by 1.
- The slot is accepted when `branch`=0 and `sq_cnt`=0.

**Accepted slot:** `idu_vld` <= 1 and all decoded fields register.

**Squashed slot:**
- `idu_vld` <= 0.
- `idu_rd`, `idu_ill` <= 0.
- All other outputs hold their previous values.

**Immediate generation** is selected by opcode:
- I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): `{{20{i[31]}},i[31:20]}`.
- S-type (STORE 0100011): `{{20{i[31]}},i[31:25],i[11:7]}`.
- B-type (BRANCH 1100011): `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`.
- U-type (LUI 0110111, AUIPC 0010111): `{i[31:12],12'b0}`.
- J-type (JAL 1101111): `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`.
- OP 0110011, MISC-MEM 0001111 and illegal opcodes: 0.

**Register file:**
- 32x32, with x0 hardwired to 0.
- Writes with `wb_rd`=0 are dropped.
- Write is synchronous on `clk`; reads are combinational.
- The storage array is not reset.

**Illegal flag** (`idu_ill`) is set when either holds:
- `ins[1:0]` != 2'b11.
- The opcode is not one of the 11 RV32I opcodes listed above.

**Destination index on illegal or no-write instructions:**
- `idu_rd` <= 0 for STORE, BRANCH and illegal instructions.
- This lets downstream logic treat `rd`=0 as "no write".

## Timing
- Latency is 1 cycle: the `ifu_*` inputs sampled at edge N appear on `idu_*` after edge N.
- All outputs reset to 0. `sq_cnt` resets to `SQ_N`.
- **After reset release:** the first 2 slots are squashed. The first `idu_vld`=1 carries `idu_pc`=0.
- **Redirect:** when `branch` is asserted in cycle T, the slots in cycles T, T+1 and T+2 are squashed. The slot in cycle T+3 carries `br_adr` and is accepted.
- **Back-to-back branches:** each branch restarts the window.
- **Reset asserted mid-operation:** all outputs clear immediately (asynchronous), and `sq_cnt` returns to `SQ_N`.
- **Write/read collision:** a `wb_we` write in cycle T is visible to a read in cycle T only when bypass is enabled (see Configuration). Without bypass it is visible from T+1.

## Configuration
`IDU_RF_BYPASS_EN`:
- **Defined:** if `wb_we`=1, `wb_rd`!=0 and `wb_rd` equals rs1 or rs2 in the same cycle, the read returns `wb_dat`.
- **Undefined:** the read returns the old array contents. Writeback-to-decode hazards are then the responsibility of the execute forwarding network.

## Structure
- **Package `u_rv_pkg`** holds:
  - the 11 opcode `localparam`s;
  - the `imm_t` enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - the default `SQ_N`.
- **Sub-module `u_regfile`:** 2 read ports, 1 write port, x0 hardwired to 0. The bypass logic lives inside it under the macro.
- **In `u_idu` itself:** squash counter, immediate mux, illegal check and output registers.

## Test plan
- **Reset release**, fetch model starting at PC 0 -> `idu_vld`=0 for 2 slots; the first valid output has `idu_pc`=0x0 and the matching instruction.
- **`ifu_ins`=0x00500093** (addi x1,x0,5) -> `idu_rd`=1, `idu_rs1`=0, `idu_rs1_dat`=0, `idu_imm`=5, `idu_ill`=0.
- **`ifu_ins`=0xFE000EE3** (beq x0,x0,-4) -> `idu_imm`=0xFFFFFFFC, `idu_rd`=0.
- **Branch redirect:** `branch` pulsed in cycle 10 to 0x100 -> `idu_vld`=0 for slots 10–12; slot 13 has `idu_pc`=0x100. Branch pulsed again in cycle 11 -> squash extends through slot 13.
- **Register file:**
  - Write x3=0xDEADBEEF and decode `add x4,x3,x0` in the same cycle -> `idu_rs1_dat`=0xDEADBEEF with `IDU_RF_BYPASS_EN` defined, and the old value without it.
  - Write to x0 -> a later read of x0 returns 0.
- **`ifu_ins`=0x00000000 and 0xFFFFFFFF** -> `idu_vld`=1, `idu_ill`=1, `idu_rd`=0. Asserting `rstn`=0 mid-stream clears all outputs within the same cycle.
